// File: rtl/vldst_sequencer.sv
// Vector load/store sequencer: turns one LDRV/STRV request into LANES word transfers on a simple memory port.
// Optional feature macro VSEQ_STRIDE_EN adds a 16-bit byte-stride input; otherwise the stride is DATA_W/8.
module vldst_sequencer #(
    parameter int LANES  = 8,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      MemW,
    input  logic                      MemToReg,
    input  logic [31:0]               base_addr,
`ifdef VSEQ_STRIDE_EN
    input  logic [15:0]               stride,
`endif
    input  logic [LANES*DATA_W-1:0]   store_vec,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [LANES*DATA_W-1:0]   load_vec,
    output logic                      stall,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                fsm_state
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W  = LANES * DATA_W;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    // Memory port handshake: a word is in flight while mem_req=1; it completes on a
    // cycle where mem_ready=1, and address/data/direction are held steady until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [LANE_W-1:0]   lane;
    logic                is_store;
    logic [31:0]         base_q;
    logic [31:0]         stride_q;
    logic [31:0]         stride_in;
    logic [VEC_W-1:0]    store_q;
    logic [VEC_W-1:0]    load_q;
    logic                err_q;
    logic                accept;
    logic                illegal;

`ifdef VSEQ_STRIDE_EN
    assign stride_in = 32'(stride);
`else
    assign stride_in = 32'(DATA_W / 8);
`endif

    assign accept  = start & (MemW ^ MemToReg);
    assign illegal = start & MemW & MemToReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lane     <= '0;
            is_store <= 1'b0;
            base_q   <= '0;
            stride_q <= '0;
            store_q  <= '0;
            load_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= (state == IDLE) && illegal;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_store <= MemW;
                        base_q   <= base_addr;
                        stride_q <= stride_in;
                        lane     <= '0;
                        if (MemW) store_q <= store_vec;
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        if (!is_store) load_q[lane*DATA_W +: DATA_W] <= mem_rdata;
                        if (lane != LAST_LANE) lane <= lane + 1'b1;
                    end
                end
                default: lane <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = XFER;
            XFER: begin
                mem_req   = 1'b1;
                mem_we    = is_store;
                // Address arithmetic deliberately wraps modulo 2^32.
                mem_addr  = base_q + 32'(lane) * stride_q;
                mem_wdata = is_store ? store_q[lane*DATA_W +: DATA_W] : '0;
                if (mem_ready && (lane == LAST_LANE)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall     = (state != IDLE);
    assign err       = err_q;
    assign load_vec  = load_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_vldst_sequencer.sv
// Directed self-checking bench for vldst_sequencer: stores, loads with stalls, illegal requests,
// mid-transfer reset, address wrap and (with VSEQ_STRIDE_EN) a custom stride.
module tb_vldst_sequencer;

  localparam int LANES  = 8;
  localparam int DATA_W = 32;
  localparam int VEC_W  = LANES * DATA_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               MemW;
  logic               MemToReg;
  logic [31:0]        base_addr;
  logic [15:0]        stride;
  logic [VEC_W-1:0]   store_vec;
  logic [DATA_W-1:0]  mem_rdata;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [VEC_W-1:0]   load_vec;
  logic               stall;
  logic               done;
  logic               err;
  logic [1:0]         fsm_state;

  int test_cnt = 0;
  int fail_cnt = 0;
  logic [31:0] exp_q[$];
  logic [VEC_W-1:0] st_vec;
  logic [VEC_W-1:0] ld_exp;

  vldst_sequencer #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .MemW      (MemW),
    .MemToReg  (MemToReg),
    .base_addr (base_addr),
`ifdef VSEQ_STRIDE_EN
    .stride    (stride),
`endif
    .store_vec (store_vec),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .load_vec  (load_vec),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One full instruction starting at the current negedge (cycle 0). A second, legal-looking
  // start with a different base is pulsed at cycle 3 and must be ignored.
  task automatic run_xfer(input logic st, input logic [31:0] base, input logic [15:0] strd,
                          input logic [VEC_W-1:0] vec, input bit toggle, input int exp_done);
    int cyc;
    int k;
    bit seen_done;
    exp_q.delete();
    for (int i = 0; i < LANES; i++) exp_q.push_back(base + 32'(i) * 32'(strd));
    start = 1'b1; MemW = st; MemToReg = !st;
    base_addr = base; stride = strd; store_vec = vec; mem_ready = 1'b0;
    check("c0_stall", stall, 0);
    check("c0_addr", mem_addr, 0);
    cyc = 0; k = 0; seen_done = 0;
    while (!seen_done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3); MemW = !st; MemToReg = st;
      base_addr = 32'hDEAD_0000; stride = 16'h0100; store_vec = ~vec;
      mem_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      mem_rdata = DATA_W'(32'hA0 + k);
      if (done) begin
        check("done_cycle", cyc, exp_done);
        check("done_req", mem_req, 0);
        check("done_addr", mem_addr, 0);
        seen_done = 1;
      end else begin
        check("stall", stall, 1);
        check("req", mem_req, 1);
        check("we", mem_we, st);
        if (exp_q.size() > 0) check("addr", mem_addr, exp_q[0]);
        else check("extra_beat", 1, 0);
        check("wdata", mem_wdata, st ? vec[k*DATA_W +: DATA_W] : '0);
        if (mem_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          k++;
        end
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    start = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("post_stall", stall, 0);
    check("post_done", done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; MemW = 1'b0; MemToReg = 1'b0;
    base_addr = '0; stride = 16'd4; store_vec = '0; mem_rdata = '0; mem_ready = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      st_vec[i*DATA_W +: DATA_W] = DATA_W'(32'h11 * (i + 1));
      ld_exp[i*DATA_W +: DATA_W] = DATA_W'(32'hA0 + i);
    end
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_load_vec", load_vec, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // store 0x11..0x88 at 0x100, ready always high
    run_xfer(1'b1, 32'h100, 16'd4, st_vec, 1'b0, LANES + 1);
    check("store_keeps_load_vec", load_vec, 0);

    // load at 0x200 with ready toggling
    run_xfer(1'b0, 32'h200, 16'd4, '0, 1'b1, 16);
    check("load_vec", load_vec, ld_exp);

    // illegal request: both MemW and MemToReg
    start = 1'b1; MemW = 1'b1; MemToReg = 1'b1; base_addr = 32'h400;
    @(negedge clk);
    start = 1'b0; MemW = 1'b0; MemToReg = 1'b0;
    check("err_pulse", err, 1);
    check("err_req", mem_req, 0);
    check("err_stall", stall, 0);
    @(negedge clk);
    check("err_clear", err, 0);
    check("err_stall2", stall, 0);
    check("err_load_vec_kept", load_vec, ld_exp);

    // start with neither direction is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("none_err", err, 0);
    check("none_stall", stall, 0);
    @(negedge clk);

    // reset after lane 3 of a load
    start = 1'b1; MemW = 1'b0; MemToReg = 1'b1; base_addr = 32'h300; stride = 16'd4;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = DATA_W'(32'h50 + c - 1);
      check("rl_addr", mem_addr, 32'h300 + 32'(4 * (c - 1)));
      check("rl_done", done, 0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) ld_exp[i*DATA_W +: DATA_W] = DATA_W'(32'h50 + i);
    check("rl_partial", load_vec, ld_exp);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rl_stall", stall, 0);
    check("rl_req", mem_req, 0);
    check("rl_load_vec", load_vec, 0);
    check("rl_done_after", done, 0);
    @(negedge clk);
    check("rl_no_done", done, 0);
    run_xfer(1'b1, 32'h100, 16'd4, st_vec, 1'b0, LANES + 1);
    check("rl_store_load_vec", load_vec, 0);

    // address wrap with default stride of 4
    run_xfer(1'b1, 32'hFFFF_FFF8, 16'd4, ~st_vec, 1'b0, LANES + 1);

`ifdef VSEQ_STRIDE_EN
    run_xfer(1'b1, 32'h0, 16'd16, st_vec, 1'b0, LANES + 1);
    run_xfer(1'b0, 32'h40, 16'd16, '0, 1'b1, 16);
    for (int i = 0; i < LANES; i++) ld_exp[i*DATA_W +: DATA_W] = DATA_W'(32'hA0 + i);
    check("stride_load_vec", load_vec, ld_exp);
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/vldst_sequencer.md
VLDST_SEQUENCER -- requirements
Module: vldst_sequencer

Interface
REQ-001 Parameter LANES, default 8: number of vector lanes transferred per instruction.
REQ-002 Parameter DATA_W, default 32: lane and memory word width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a vector memory instruction; sampled only in IDLE.
REQ-006 MemW  input  1  store request (STRV) from the main decoder.
REQ-007 MemToReg  input  1  load request (LDRV) from the main decoder.
REQ-008 base_addr  input  32  byte address of lane 0.
REQ-009 store_vec  input  LANES*DATA_W  source vector; lane i at bits [i*DATA_W +: DATA_W].
REQ-010 mem_rdata  input  DATA_W  read data, valid in the cycle mem_ready=1 during a load.
REQ-011 mem_ready  input  1  memory accepts/completes the current word this cycle.
REQ-012 mem_req  output  1  word transfer requested.
REQ-013 mem_we  output  1  1 = write, 0 = read; meaningful only while mem_req=1.
REQ-014 mem_addr  output  32  byte address of the current word.
REQ-015 mem_wdata  output  DATA_W  store data for the current lane.
REQ-016 load_vec  output  LANES*DATA_W  assembled load result, layout as store_vec.
REQ-017 stall  output  1  pipeline stall; high whenever state is not IDLE.
REQ-018 done  output  1  one-cycle pulse on instruction completion.
REQ-019 err  output  1  one-cycle pulse on illegal request.

Function
REQ-020 FSM states SHALL be IDLE, XFER, DONE.
REQ-021 IDLE with start=1 and exactly one of MemW/MemToReg SHALL latch the direction, base_addr, and store_vec (for stores), clear the lane counter to 0, and enter XFER next cycle.
REQ-022 IDLE with start=1, MemW=1 and MemToReg=1 SHALL pulse err the next cycle, perform no transfer, and remain IDLE.
REQ-023 IDLE with start=1 and MemW=0, MemToReg=0 SHALL be ignored (no err, no transfer).
REQ-024 start SHALL be ignored in XFER and DONE; inputs other than mem_rdata/mem_ready SHALL NOT affect an instruction in progress.
REQ-025 In XFER, mem_req SHALL be 1, mem_we SHALL equal the latched store direction, mem_addr SHALL equal latched base + lane*stride (modulo 2^32), and mem_wdata SHALL equal latched lane[lane] for stores, 0 for loads.
REQ-026 In XFER, mem_ready=0 SHALL hold all outputs and the counter unchanged (unbounded wait allowed).
REQ-027 In XFER, mem_ready=1 on a load SHALL write mem_rdata into load_vec lane[lane]; other lanes SHALL be unchanged.
REQ-028 In XFER, mem_ready=1 with lane<LANES-1 SHALL increment lane; with lane=LANES-1 SHALL enter DONE.
REQ-029 DONE SHALL last exactly one cycle with done=1, mem_req=0, then return to IDLE.
REQ-030 Latency with mem_ready held 1: start at cycle 0 -> first mem_req at cycle 1 -> done at cycle LANES+1 -> stall low at cycle LANES+2.
REQ-031 load_vec SHALL retain its value after a load until the next load overwrites lanes; stores SHALL NOT modify it.
REQ-032 Outside XFER, mem_req, mem_we SHALL be 0; mem_addr and mem_wdata SHALL be 0.

Reset
REQ-033 rst=1 SHALL, at the next edge, force IDLE, lane=0, and all outputs to 0 (including load_vec), overriding any other input.
REQ-034 rst asserted mid-XFER SHALL abandon the transfer with no done pulse; partially loaded lanes SHALL be cleared.

Configuration
REQ-035 Macro VSEQ_STRIDE_EN defined: adds input stride (16 bits, unsigned byte stride) latched at start alongside base_addr.
REQ-036 VSEQ_STRIDE_EN undefined: no stride port; stride SHALL be the constant DATA_W/8 (4 bytes at default).

Verification
REQ-037 Store, base_addr=0x100, store_vec lanes = 0x11..0x88, mem_ready=1 -> 8 writes at 0x100..0x11C with data 0x11..0x88, done at cycle 9.
REQ-038 Load, base_addr=0x200, mem_rdata = 0xA0+lane, mem_ready toggling 1/0 -> load_vec lanes 0xA0..0xA7, done at cycle 16, stall high throughout.
REQ-039 start with MemW=1 and MemToReg=1 -> err pulse next cycle, mem_req stays 0, stall stays 0.
REQ-040 rst asserted after lane 3 of a load -> next cycle IDLE, load_vec=0, no done; new store afterwards completes normally.
REQ-041 base_addr=0xFFFFFFF8 store -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ..., 0x14 (wrap); with VSEQ_STRIDE_EN and stride=16, base 0 -> addresses 0x0..0x70 step 0x10.
REQ-042 start pulsed again mid-XFER with different base_addr -> ignored; original sequence completes unchanged.
